// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: write port, two read ports,
// bulk-clear request and status.
interface register_file_param_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;
  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic          CLR;
  logic [DW-1:0] busX;
  logic [DW-1:0] busY;
  logic          BUSY;
  logic          WERR;

  modport master (
    output WEN, RW, busW, RX, RY, CLR,
    input  busX, busY, BUSY, WERR
  );

  modport slave (
    input  WEN, RW, busW, RX, RY, CLR,
    output busX, busY, BUSY, WERR
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised two-read-port register file with optional zero register,
// optional registered reads with write bypass, and a sequenced bulk clear.
//
// state | meaning
// IDLE  | normal operation, writes accepted
// SWEEP | bulk clear, one entry zeroed per cycle, BUSY high
module register_file_param #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit READ_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                  Clk,
  input logic                  Rst_n,
  register_file_param_if.slave bus
);
  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic          busy;
  logic          sweep_en;
  logic          wr_acc;
  logic          wr_drop;
  logic          werr_q;
  logic [DW-1:0] rd_x;
  logic [DW-1:0] rd_y;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    sweep_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLR) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        busy     = 1'b1;
        sweep_en = 1'b1;
        cnt_nxt  = cnt + AW'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // CLR wins over a same-edge write; writes to entry 0 vanish under ZERO_REG
  assign wr_acc  = bus.WEN && !busy && !bus.CLR && !(ZERO_REG && (bus.RW == '0));
  assign wr_drop = bus.WEN && (busy || bus.CLR);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep_en) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      mem[bus.RW] <= bus.busW;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) werr_q <= 1'b0;
    else        werr_q <= wr_drop;
  end

  always_comb begin
    rd_x = mem[bus.RX];
    if (ZERO_REG && (bus.RX == '0))                   rd_x = '0;
    else if (BYPASS && wr_acc && (bus.RW == bus.RX)) rd_x = bus.busW;
  end

  always_comb begin
    rd_y = mem[bus.RY];
    if (ZERO_REG && (bus.RY == '0))                   rd_y = '0;
    else if (BYPASS && wr_acc && (bus.RW == bus.RY)) rd_y = bus.busW;
  end

  generate
    if (READ_REG) begin : g_rd_reg
      logic [DW-1:0] x_q;
      logic [DW-1:0] y_q;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else begin
          x_q <= rd_x;
          y_q <= rd_y;
        end
      end
      assign bus.busX = x_q;
      assign bus.busY = y_q;
    end else begin : g_rd_comb
      assign bus.busX = rd_x;
      assign bus.busY = rd_y;
    end
  endgenerate

  assign bus.BUSY = busy;
  assign bus.WERR = werr_q;
endmodule
